// File: rtl/adc_scan_fsm.sv
// ADS1115-style multi-channel scanner: per channel writes config, waits for the
// conversion, sets the pointer and reads two bytes through the shared I2C master port.
module adc_scan_fsm #(
  parameter int         MAX_BYTES_PER_TRANSACTION = 3,
  parameter int         NUM_CH                    = 4,
  parameter logic [6:0] SLAVE_ADDR                = 7'h48,
  parameter logic [2:0] PGA                       = 3'b001,
  parameter logic [2:0] DR                        = 3'b100,
  parameter int         CONV_WAIT_CLKS            = 1000000,
  parameter int         SAMPLE_PERIOD_CLKS        = 6250000,
  parameter int         MAX_RETRIES               = 3,
  localparam int        BW = $clog2(MAX_BYTES_PER_TRANSACTION + 1)
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        enable,
  input  logic                                        i2c_transaction_done,
  input  logic                                        i2c_ack_err,
  input  logic [MAX_BYTES_PER_TRANSACTION-1:0][7:0]   i2c_master_dout,
  output logic                                        i2c_transaction_start,
  output logic                                        i2c_transaction_rd_nwr,
  output logic [6:0]                                  i2c_transaction_slave_addr,
  output logic [MAX_BYTES_PER_TRANSACTION-1:0][7:0]   i2c_master_din,
  output logic [BW-1:0]                               i2c_transaction_bytes_num,
  output logic [NUM_CH-1:0][15:0]                     ch_data,
  output logic                                        sample_valid,
  output logic [1:0]                                  sample_ch,
  output logic                                        scan_done,
  output logic                                        scan_overrun,
  output logic [7:0]                                  err_count,
  output logic                                        busy
);

  localparam int PW = (SAMPLE_PERIOD_CLKS > 2) ? $clog2(SAMPLE_PERIOD_CLKS) : 1;
  localparam int CW = (CONV_WAIT_CLKS > 2) ? $clog2(CONV_WAIT_CLKS) : 1;
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [PW-1:0] PER_LOAD  = PW'(SAMPLE_PERIOD_CLKS - 1);
  // The CONV entry cycle and the PTR cycle both count toward the wait.
  localparam logic [CW-1:0] CONV_LOAD = (CONV_WAIT_CLKS > 2) ? CW'(CONV_WAIT_CLKS - 2) : '0;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [1:0]    LAST_CH   = 2'(NUM_CH - 1);

  typedef enum logic [3:0] {
    IDLE, CFG, CFG_WAIT, CONV, PTR, PTR_WAIT, READ, READ_WAIT, NEXT, PERIOD
  } state_t;

  state_t                                   state_q, state_d;
  logic [1:0]                               ch_q, ch_d;
  logic [RW-1:0]                            retry_q, retry_d;
  logic [PW-1:0]                            per_q, per_d;
  logic [CW-1:0]                            conv_q, conv_d;
  logic                                     ovr_q, ovr_d;
  logic                                     start_q, start_d;
  logic                                     rd_nwr_q, rd_nwr_d;
  logic [MAX_BYTES_PER_TRANSACTION-1:0][7:0] din_q, din_d;
  logic [BW-1:0]                            bytes_q, bytes_d;
  logic [NUM_CH-1:0][15:0]                  ch_data_q, ch_data_d;
  logic                                     sv_q, sv_d;
  logic                                     sdone_q, sdone_d;
  logic                                     overrun_q, overrun_d;
  logic [7:0]                               err_q, err_d;
  logic                                     busy_q, busy_d;
  logic                                     new_scan, nack;
  logic                                     unused_dout;

  assign unused_dout = ^i2c_master_dout;

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    retry_d   = retry_q;
    per_d     = (per_q != '0) ? per_q - PW'(1) : per_q;
    conv_d    = conv_q;
    ovr_d     = ovr_q;
    start_d   = 1'b0;
    rd_nwr_d  = rd_nwr_q;
    din_d     = din_q;
    bytes_d   = bytes_q;
    ch_data_d = ch_data_q;
    sv_d      = 1'b0;
    sdone_d   = 1'b0;
    overrun_d = 1'b0;
    err_d     = err_q;
    new_scan  = 1'b0;
    nack      = 1'b0;

    // Period expiry at the final NEXT is an exact fit, not an overrun.
    if (per_q == '0 && !ovr_q && state_q != IDLE && state_q != PERIOD &&
        !(state_q == NEXT && ch_q == LAST_CH)) begin
      overrun_d = 1'b1;
      ovr_d     = 1'b1;
    end

    case (state_q)
      IDLE: begin
        ch_d = '0;
        if (enable) new_scan = 1'b1;
      end
      CFG:  state_d = CFG_WAIT;
      PTR:  state_d = PTR_WAIT;
      READ: state_d = READ_WAIT;
      CFG_WAIT: begin
        if (i2c_transaction_done) begin
          if (i2c_ack_err) nack = 1'b1;
          else begin
            state_d = CONV;
            conv_d  = CONV_LOAD;
          end
        end
      end
      CONV: begin
        if (conv_q == '0) state_d = PTR;
        else conv_d = conv_q - CW'(1);
      end
      PTR_WAIT: begin
        if (i2c_transaction_done) begin
          if (i2c_ack_err) nack = 1'b1;
          else state_d = READ;
        end
      end
      READ_WAIT: begin
        if (i2c_transaction_done) begin
          if (i2c_ack_err) nack = 1'b1;
          else begin
            for (int i = 0; i < NUM_CH; i++) begin
              if (ch_q == 2'(i)) ch_data_d[i] = {i2c_master_dout[0], i2c_master_dout[1]};
            end
            sv_d    = 1'b1;
            state_d = NEXT;
          end
        end
      end
      NEXT: begin
        retry_d = '0;
        if (ch_q != LAST_CH) begin
          ch_d    = ch_q + 2'd1;
          state_d = CFG;
        end else begin
          sdone_d = 1'b1;
          if (!enable) state_d = IDLE;
          else if (per_q == '0) new_scan = 1'b1;
          else state_d = PERIOD;
        end
      end
      PERIOD: begin
        if (per_q == '0) begin
          if (enable) new_scan = 1'b1;
          else state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (nack) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      if (retry_q == RETRY_MAX) state_d = NEXT;
      else begin
        retry_d = retry_q + RW'(1);
        state_d = CFG;
      end
    end

    if (new_scan) begin
      state_d = CFG;
      ch_d    = '0;
      retry_d = '0;
      per_d   = PER_LOAD;
      ovr_d   = 1'b0;
    end

    // Transaction fields are loaded on entry to the one-cycle request states.
    case (state_d)
      CFG: begin
        start_d  = 1'b1;
        rd_nwr_d = 1'b0;
        bytes_d  = BW'(3);
        din_d    = '0;
        din_d[0] = 8'h01;
        din_d[1] = {2'b11, ch_d, PGA, 1'b1};
        din_d[2] = {DR, 5'b00011};
      end
      PTR: begin
        start_d  = 1'b1;
        rd_nwr_d = 1'b0;
        bytes_d  = BW'(1);
        din_d    = '0;
      end
      READ: begin
        start_d  = 1'b1;
        rd_nwr_d = 1'b1;
        bytes_d  = BW'(2);
      end
      default: ;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      retry_q   <= '0;
      per_q     <= '0;
      conv_q    <= '0;
      ovr_q     <= 1'b0;
      start_q   <= 1'b0;
      rd_nwr_q  <= 1'b0;
      din_q     <= '0;
      bytes_q   <= BW'(1);
      ch_data_q <= '0;
      sv_q      <= 1'b0;
      sdone_q   <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      retry_q   <= retry_d;
      per_q     <= per_d;
      conv_q    <= conv_d;
      ovr_q     <= ovr_d;
      start_q   <= start_d;
      rd_nwr_q  <= rd_nwr_d;
      din_q     <= din_d;
      bytes_q   <= bytes_d;
      ch_data_q <= ch_data_d;
      sv_q      <= sv_d;
      sdone_q   <= sdone_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign i2c_transaction_start      = start_q;
  assign i2c_transaction_rd_nwr     = rd_nwr_q;
  assign i2c_transaction_slave_addr = SLAVE_ADDR;
  assign i2c_master_din             = din_q;
  assign i2c_transaction_bytes_num  = bytes_q;
  assign ch_data                    = ch_data_q;
  assign sample_valid               = sv_q;
  assign sample_ch                  = ch_q;
  assign scan_done                  = sdone_q;
  assign scan_overrun               = overrun_q;
  assign err_count                  = err_q;
  assign busy                       = busy_q;

endmodule

// File: tb/tb_adc_scan_fsm.sv
// Directed bench for adc_scan_fsm: the initial block plays the I2C master and
// checks transaction fields, timing, retries, overrun, disable and mid-read reset.
module tb_adc_scan_fsm;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             enable = 1'b0;
  logic             done = 1'b0;
  logic             ack_err = 1'b0;
  logic [2:0][7:0]  dout = '0;
  logic             start, rd_nwr, sample_valid, scan_done, scan_overrun, busy;
  logic [6:0]       slave_addr;
  logic [2:0][7:0]  din;
  logic [1:0]       bytes_num;
  logic [1:0][15:0] ch_data;
  logic [1:0]       sample_ch;
  logic [7:0]       err_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ov_cnt = 0;
  int last_start_cyc = 0;
  int last_done_cyc = 0;
  int s1, s2, s3, d_cfg, n_starts;

  adc_scan_fsm #(
    .MAX_BYTES_PER_TRANSACTION(3),
    .NUM_CH(2),
    .SLAVE_ADDR(7'h48),
    .PGA(3'b001),
    .DR(3'b100),
    .CONV_WAIT_CLKS(10),
    .SAMPLE_PERIOD_CLKS(2000),
    .MAX_RETRIES(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .i2c_transaction_done(done),
    .i2c_ack_err(ack_err),
    .i2c_master_dout(dout),
    .i2c_transaction_start(start),
    .i2c_transaction_rd_nwr(rd_nwr),
    .i2c_transaction_slave_addr(slave_addr),
    .i2c_master_din(din),
    .i2c_transaction_bytes_num(bytes_num),
    .ch_data(ch_data),
    .sample_valid(sample_valid),
    .sample_ch(sample_ch),
    .scan_done(scan_done),
    .scan_overrun(scan_overrun),
    .err_count(err_count),
    .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(posedge clk) begin
    #1;
    if (scan_overrun === 1'b1) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_start"}, start, 0);
    chk({tag, "_rd_nwr"}, rd_nwr, 0);
    chk({tag, "_addr"}, slave_addr, 7'h48);
    chk({tag, "_din"}, din, 0);
    chk({tag, "_bytes"}, bytes_num, 1);
    chk({tag, "_ch_data"}, ch_data, 0);
    chk({tag, "_sv"}, sample_valid, 0);
    chk({tag, "_sample_ch"}, sample_ch, 0);
    chk({tag, "_scan_done"}, scan_done, 0);
    chk({tag, "_overrun"}, scan_overrun, 0);
    chk({tag, "_err"}, err_count, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Waits (bounded) for a start pulse, checks the request fields and the 1-cycle width.
  task automatic see_start(input string tag, input logic exp_rd, input int exp_bytes,
                           input int ncmp, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2);
    int n = 0;
    while (start !== 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_start"}, start, 1);
    last_start_cyc = cyc;
    chk({tag, "_rd_nwr"}, rd_nwr, exp_rd);
    chk({tag, "_bytes"}, bytes_num, exp_bytes);
    if (ncmp > 0) chk({tag, "_din0"}, din[0], b0);
    if (ncmp > 2) begin
      chk({tag, "_din1"}, din[1], b1);
      chk({tag, "_din2"}, din[2], b2);
    end
    @(negedge clk);
    chk({tag, "_pulse"}, start, 0);
  endtask

  task automatic respond(input int lat, input logic nack, input logic [7:0] r0, input logic [7:0] r1);
    repeat (lat - 1) @(negedge clk);
    done = 1'b1;
    ack_err = nack;
    dout[0] = r0;
    dout[1] = r1;
    last_done_cyc = cyc;
    @(negedge clk);
    done = 1'b0;
    ack_err = 1'b0;
  endtask

  task automatic txn_cfg(input string tag, input logic [7:0] cfg1, input int lat, input logic nack);
    see_start(tag, 1'b0, 3, 3, 8'h01, cfg1, 8'h83);
    respond(lat, nack, 8'h00, 8'h00);
  endtask

  task automatic txn_ptr(input string tag, input int lat);
    see_start(tag, 1'b0, 1, 1, 8'h00, 8'h00, 8'h00);
    respond(lat, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic txn_read(input string tag, input int lat, input logic [7:0] r0, input logic [7:0] r1);
    see_start(tag, 1'b1, 2, 0, 8'h00, 8'h00, 8'h00);
    respond(lat, 1'b0, r0, r1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset("rst");
    reset = 1'b0;
    enable = 1'b1;

    // scan 1: plain two-channel pass
    txn_cfg("s1c0_cfg", 8'hC3, 3, 1'b0);
    s1 = last_start_cyc;
    d_cfg = last_done_cyc;
    txn_ptr("s1c0_ptr", 2);
    chk("conv_wait", last_start_cyc - d_cfg, 10);
    txn_read("s1c0_rd", 4, 8'hAB, 8'hCD);
    chk("s1c0_sv", sample_valid, 1);
    chk("s1c0_data", ch_data[0], 16'hABCD);
    chk("s1c0_sample_ch", sample_ch, 0);
    txn_cfg("s1c1_cfg", 8'hD3, 3, 1'b0);
    txn_ptr("s1c1_ptr", 2);
    txn_read("s1c1_rd", 3, 8'h12, 8'h34);
    chk("s1c1_sv", sample_valid, 1);
    chk("s1c1_data", ch_data[1], 16'h1234);
    chk("s1c1_sample_ch", sample_ch, 1);
    chk("s1c1_busy", busy, 1);
    @(negedge clk);
    chk("s1_sv_width", sample_valid, 0);
    chk("s1_scan_done", scan_done, 1);
    chk("s1_data0_held", ch_data[0], 16'hABCD);
    @(negedge clk);
    chk("s1_done_width", scan_done, 0);
    chk("s1_period_busy", busy, 1);
    chk("s1_period_nostart", start, 0);

    // scan 2: two CFG NACKs then success on ch0
    txn_cfg("s2c0_cfg_n1", 8'hC3, 2, 1'b1);
    s2 = last_start_cyc;
    chk("period_s1_s2", s2 - s1, 2000);
    txn_cfg("s2c0_cfg_n2", 8'hC3, 2, 1'b1);
    txn_cfg("s2c0_cfg_ok", 8'hC3, 2, 1'b0);
    txn_ptr("s2c0_ptr", 2);
    txn_read("s2c0_rd", 2, 8'h56, 8'h78);
    chk("s2c0_sv", sample_valid, 1);
    chk("s2c0_data", ch_data[0], 16'h5678);
    chk("s2_err", err_count, 2);
    txn_cfg("s2c1_cfg", 8'hD3, 2, 1'b0);
    txn_ptr("s2c1_ptr", 2);
    txn_read("s2c1_rd", 2, 8'h11, 8'h11);
    chk("s2c1_data", ch_data[1], 16'h1111);

    // scan 3: ch0 NACKed four times and skipped; slow ch1 forces an overrun
    txn_cfg("s3c0_cfg_n1", 8'hC3, 2, 1'b1);
    s3 = last_start_cyc;
    chk("period_s2_s3", s3 - s2, 2000);
    for (int i = 0; i < 3; i++) txn_cfg("s3c0_cfg_nr", 8'hC3, 2, 1'b1);
    chk("s3_err", err_count, 6);
    chk("s3_sv_skip", sample_valid, 0);
    chk("s3c0_data_held", ch_data[0], 16'h5678);
    txn_cfg("s3c1_cfg", 8'hD3, 2100, 1'b0);
    chk("s3_overrun_once", ov_cnt, 1);
    txn_ptr("s3c1_ptr", 2);
    txn_read("s3c1_rd", 2, 8'hAA, 8'h55);
    chk("s3c1_data", ch_data[1], 16'hAA55);
    chk("s3c0_data_still", ch_data[0], 16'h5678);
    @(negedge clk);
    chk("s3_scan_done", scan_done, 1);
    chk("s3_restart_now", start, 1);
    chk("s3_restart_din1", din[1], 8'hC3);
    enable = 1'b0;

    // scan 4: enable dropped during ch0, scan completes then idles
    txn_cfg("s4c0_cfg", 8'hC3, 2, 1'b0);
    txn_ptr("s4c0_ptr", 2);
    txn_read("s4c0_rd", 2, 8'h01, 8'h02);
    chk("s4c0_data", ch_data[0], 16'h0102);
    txn_cfg("s4c1_cfg", 8'hD3, 2, 1'b0);
    txn_ptr("s4c1_ptr", 2);
    txn_read("s4c1_rd", 2, 8'h99, 8'h99);
    chk("s4c1_sv", sample_valid, 1);
    chk("s4c1_data", ch_data[1], 16'h9999);
    @(negedge clk);
    chk("s4_scan_done", scan_done, 1);
    chk("s4_idle_busy", busy, 0);
    n_starts = 0;
    repeat (2500) begin
      @(negedge clk);
      if (start === 1'b1) n_starts++;
    end
    chk("idle_no_start", n_starts, 0);
    chk("idle_busy", busy, 0);
    chk("overrun_total", ov_cnt, 1);

    // reset asserted while waiting on the read
    enable = 1'b1;
    txn_cfg("s5c0_cfg", 8'hC3, 2, 1'b0);
    txn_ptr("s5c0_ptr", 2);
    see_start("s5c0_rd", 1'b1, 2, 0, 8'h00, 8'h00, 8'h00);
    reset = 1'b1;
    @(negedge clk);
    check_reset("midrst");
    reset = 1'b0;
    txn_cfg("s6c0_cfg", 8'hC3, 2, 1'b0);
    chk("s6_sample_ch", sample_ch, 0);
    chk("s6_busy", busy, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
